// File: rtl/aes_round_sequencer_if.sv
// Handshake and control bundle between the AES round sequencer and its
// environment: start/mode/key-ready inputs, per-cycle op enables and status.
interface aes_round_sequencer_if;
  logic       i_start;
  logic       i_mode;
  logic       i_key_ready;
  logic       o_busy;
  logic       o_done;
  logic       o_load_state;
  logic       o_sub_en;
  logic       o_shift_en;
  logic       o_mix_en;
  logic       o_ark_en;
  logic       o_inv;
  logic [3:0] o_round;
  logic [3:0] o_key_sel;

  modport master (
    output i_start, i_mode, i_key_ready,
    input  o_busy, o_done, o_load_state, o_sub_en, o_shift_en, o_mix_en,
           o_ark_en, o_inv, o_round, o_key_sel
  );

  modport slave (
    input  i_start, i_mode, i_key_ready,
    output o_busy, o_done, o_load_state, o_sub_en, o_shift_en, o_mix_en,
           o_ark_en, o_inv, o_round, o_key_sel
  );
endinterface

// File: rtl/aes_round_sequencer.sv
// Iterative AES round scheduler: steps a one-round datapath through LOAD, INIT
// (AddRoundKey), NR-1 full rounds and a final round, stalling on key readiness.
module aes_round_sequencer #(
  parameter int NR = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  aes_round_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_INIT,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_t;

  localparam logic [3:0] LP_NR   = 4'(NR);
  localparam logic [3:0] LP_LAST = 4'(NR - 1);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_round, w_round_nxt;
  logic       r_inv, w_inv_nxt;
  logic [3:0] w_key_sel;
  logic       w_kr;

  assign w_kr = bus.i_key_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_round <= 4'd0;
      r_inv   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_round <= w_round_nxt;
      r_inv   <= w_inv_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_round_nxt = r_round;
    w_inv_nxt   = r_inv;
    case (r_state)
      S_IDLE: begin
        if (bus.i_start) begin
          w_state_nxt = S_LOAD;
          w_round_nxt = 4'd0;
          w_inv_nxt   = bus.i_mode;
        end
      end
      S_LOAD: w_state_nxt = S_INIT;
      S_INIT: begin
        if (w_kr) begin
          w_round_nxt = 4'd1;
          w_state_nxt = (NR > 1) ? S_ROUND : S_FINAL;
        end
      end
      S_ROUND: begin
        if (w_kr) begin
          w_round_nxt = r_round + 4'd1;
          if (r_round == LP_LAST) w_state_nxt = S_FINAL;
        end
      end
      S_FINAL: if (w_kr) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Key index runs backwards when decrypting so the schedule is walked NR..0.
  always_comb begin
    w_key_sel = 4'd0;
    case (r_state)
      S_INIT:  w_key_sel = r_inv ? LP_NR : 4'd0;
      S_ROUND: w_key_sel = r_inv ? (LP_NR - r_round) : r_round;
      S_FINAL: w_key_sel = r_inv ? 4'd0 : LP_NR;
      default: w_key_sel = 4'd0;
    endcase
  end

  assign bus.o_busy       = (r_state != S_IDLE);
  assign bus.o_done       = (r_state == S_DONE);
  assign bus.o_load_state = (r_state == S_LOAD);
  assign bus.o_ark_en     = w_kr && ((r_state == S_INIT) || (r_state == S_ROUND) ||
                                     (r_state == S_FINAL));
  assign bus.o_sub_en     = w_kr && ((r_state == S_ROUND) || (r_state == S_FINAL));
  assign bus.o_shift_en   = w_kr && ((r_state == S_ROUND) || (r_state == S_FINAL));
  assign bus.o_mix_en     = w_kr && (r_state == S_ROUND);
  assign bus.o_inv        = r_inv;
  assign bus.o_round      = r_round;
  assign bus.o_key_sel    = w_key_sel;

endmodule
